// File: rtl/instr_issue_if.sv
// Fetch-to-decoder issue bus: instruction handshake in, registered opcode/multiDiv bundle out.
interface instr_issue_if;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;
  logic [3:0]  opcode;
  logic [3:0]  funct;
  logic [3:0]  op1;
  logic [3:0]  op2;
  logic        multiDiv;
  logic        issue_valid;
  logic        md_busy;
  logic [15:0] issued_count;

  modport master (
    input  instr_in, instr_valid, flush,
    output instr_ready, opcode, funct, op1, op2, multiDiv, issue_valid, md_busy, issued_count
  );

  modport slave (
    output instr_in, instr_valid, flush,
    input  instr_ready, opcode, funct, op1, op2, multiDiv, issue_valid, md_busy, issued_count
  );
endinterface

// File: rtl/instr_issue.sv
// Registers fetched instructions and issues them to the control decoder,
// holding type-A multiply/divide for MD_LATENCY cycles; flush drops to a bubble.
module instr_issue #(
  parameter int unsigned MD_LATENCY = 4,
  parameter logic [3:0]  NOP_OPCODE = 4'b0000,
  parameter logic [3:0]  MUL_FUNCT  = 4'b0100,
  parameter logic [3:0]  DIV_FUNCT  = 4'b0101
) (
  input  logic          clk,
  input  logic          rst,
  instr_issue_if.master bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [3:0]  TYPE_A_OPCODE = 4'b1111;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ISSUE   = 2'd1,
    MD_WAIT = 2'd2
  } state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [3:0]       opcodeNext, functNext, op1Next, op2Next;
  logic             multiDivNext, issueValidNext, mdBusyNext;
  logic [15:0]      countNext;
  logic             accept;
  logic             isMd;

  assign bus.instr_ready = !bus.flush &&
                           (state == EMPTY || state == ISSUE ||
                            (state == MD_WAIT && cnt == '0));
  assign accept = bus.instr_valid && bus.instr_ready;
  assign isMd   = (bus.instr_in[15:12] == TYPE_A_OPCODE) &&
                  (bus.instr_in[3:0] == MUL_FUNCT || bus.instr_in[3:0] == DIV_FUNCT);

  // Next-state and next-output selection; accept takes precedence over draining.
  always_comb begin
    stateNext      = state;
    cntNext        = cnt;
    opcodeNext     = bus.opcode;
    functNext      = bus.funct;
    op1Next        = bus.op1;
    op2Next        = bus.op2;
    multiDivNext   = bus.multiDiv;
    issueValidNext = bus.issue_valid;
    mdBusyNext     = bus.md_busy;
    countNext      = bus.issued_count;

    if (bus.flush) begin
      stateNext      = EMPTY;
      cntNext        = '0;
      opcodeNext     = NOP_OPCODE;
      multiDivNext   = 1'b0;
      issueValidNext = 1'b0;
      mdBusyNext     = 1'b0;
    end else if (accept) begin
      stateNext      = isMd ? MD_WAIT : ISSUE;
      cntNext        = isMd ? CNT_W'(MD_LATENCY - 1) : '0;
      opcodeNext     = bus.instr_in[15:12];
      op1Next        = bus.instr_in[11:8];
      op2Next        = bus.instr_in[7:4];
      functNext      = bus.instr_in[3:0];
      multiDivNext   = isMd;
      issueValidNext = 1'b1;
      mdBusyNext     = isMd && (MD_LATENCY > 1);
      countNext      = bus.issued_count + 16'd1;
    end else begin
      case (state)
        ISSUE: begin
          stateNext      = EMPTY;
          opcodeNext     = NOP_OPCODE;
          multiDivNext   = 1'b0;
          issueValidNext = 1'b0;
          mdBusyNext     = 1'b0;
        end
        MD_WAIT: begin
          if (cnt != '0) begin
            cntNext    = cnt - CNT_W'(1);
            mdBusyNext = (cnt != CNT_W'(1));
          end else begin
            stateNext      = EMPTY;
            opcodeNext     = NOP_OPCODE;
            multiDivNext   = 1'b0;
            issueValidNext = 1'b0;
            mdBusyNext     = 1'b0;
          end
        end
        default: begin
          stateNext      = EMPTY;
          opcodeNext     = NOP_OPCODE;
          multiDivNext   = 1'b0;
          issueValidNext = 1'b0;
          mdBusyNext     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= EMPTY;
      cnt              <= '0;
      bus.opcode       <= NOP_OPCODE;
      bus.funct        <= '0;
      bus.op1          <= '0;
      bus.op2          <= '0;
      bus.multiDiv     <= 1'b0;
      bus.issue_valid  <= 1'b0;
      bus.md_busy      <= 1'b0;
      bus.issued_count <= '0;
    end else begin
      state            <= stateNext;
      cnt              <= cntNext;
      bus.opcode       <= opcodeNext;
      bus.funct        <= functNext;
      bus.op1          <= op1Next;
      bus.op2          <= op2Next;
      bus.multiDiv     <= multiDivNext;
      bus.issue_valid  <= issueValidNext;
      bus.md_busy      <= mdBusyNext;
      bus.issued_count <= countNext;
    end
  end

endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue with MD_LATENCY=4.
module tb_instr_issue;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  instr_issue_if ifc ();

  instr_issue #(.MD_LATENCY(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = 16'h1123;
    ifc.flush       = 1'b0;
    tick();
    tick();
    chk("rst_opcode", 16'(ifc.opcode), 16'h0);
    chk("rst_issue_valid", 16'(ifc.issue_valid), 16'h0);
    chk("rst_multiDiv", 16'(ifc.multiDiv), 16'h0);
    chk("rst_count", ifc.issued_count, 16'h0000);
    rst             = 1'b0;
    ifc.instr_valid = 1'b0;
    #1;
    chk("rst_ready", 16'(ifc.instr_ready), 16'h1);

    // back-to-back issue
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = 16'h1123;
    tick();
    chk("b2b_op0", 16'(ifc.opcode), 16'h1);
    chk("b2b_iv0", 16'(ifc.issue_valid), 16'h1);
    chk("b2b_f0", {ifc.op1, ifc.op2, ifc.funct}, 16'h0123);
    ifc.instr_in = 16'h2456;
    tick();
    chk("b2b_op1", 16'(ifc.opcode), 16'h2);
    chk("b2b_iv1", 16'(ifc.issue_valid), 16'h1);
    ifc.instr_in = 16'hA000;
    tick();
    chk("b2b_op2", 16'(ifc.opcode), 16'hA);
    chk("b2b_iv2", 16'(ifc.issue_valid), 16'h1);
    chk("b2b_count", ifc.issued_count, 16'd3);
    ifc.instr_valid = 1'b0;
    tick();
    chk("b2b_bubble_op", 16'(ifc.opcode), 16'h0);
    chk("b2b_bubble_iv", 16'(ifc.issue_valid), 16'h0);

    // multiply held for 4 cycles with next word waiting
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = 16'hF124;
    tick();
    ifc.instr_in = 16'h2456;
    chk("mul_c1_md", 16'(ifc.multiDiv), 16'h1);
    chk("mul_c1_busy", 16'(ifc.md_busy), 16'h1);
    chk("mul_c1_rdy", 16'(ifc.instr_ready), 16'h0);
    chk("mul_c1_f", {ifc.opcode, ifc.op1, ifc.op2, ifc.funct}, 16'hF124);
    tick();
    chk("mul_c2_md", 16'(ifc.multiDiv), 16'h1);
    chk("mul_c2_busy", 16'(ifc.md_busy), 16'h1);
    chk("mul_c2_rdy", 16'(ifc.instr_ready), 16'h0);
    tick();
    chk("mul_c3_md", 16'(ifc.multiDiv), 16'h1);
    chk("mul_c3_busy", 16'(ifc.md_busy), 16'h1);
    chk("mul_c3_rdy", 16'(ifc.instr_ready), 16'h0);
    tick();
    chk("mul_c4_md", 16'(ifc.multiDiv), 16'h1);
    chk("mul_c4_busy", 16'(ifc.md_busy), 16'h0);
    chk("mul_c4_rdy", 16'(ifc.instr_ready), 16'h1);
    chk("mul_c4_op", 16'(ifc.opcode), 16'hF);
    tick();
    chk("mul_c5_op", 16'(ifc.opcode), 16'h2);
    chk("mul_c5_md", 16'(ifc.multiDiv), 16'h0);
    chk("mul_c5_iv", 16'(ifc.issue_valid), 16'h1);
    chk("mul_count", ifc.issued_count, 16'd5);
    ifc.instr_valid = 1'b0;
    tick();
    chk("mul_bubble_iv", 16'(ifc.issue_valid), 16'h0);

    // type-A non-md, and mul funct under another opcode
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = 16'hF120;
    tick();
    chk("nmd_a_op", 16'(ifc.opcode), 16'hF);
    chk("nmd_a_md", 16'(ifc.multiDiv), 16'h0);
    ifc.instr_valid = 1'b0;
    tick();
    chk("nmd_a_1cyc", 16'(ifc.issue_valid), 16'h0);
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = 16'h5124;
    tick();
    chk("nmd_5_op", 16'(ifc.opcode), 16'h5);
    chk("nmd_5_md", 16'(ifc.multiDiv), 16'h0);
    chk("nmd_count", ifc.issued_count, 16'd7);
    ifc.instr_valid = 1'b0;
    tick();

    // flush in cycle 2 of a divide
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = 16'hF125;
    tick();
    ifc.instr_in = 16'h1123;
    chk("div_c1_md", 16'(ifc.multiDiv), 16'h1);
    tick();
    chk("div_c2_busy", 16'(ifc.md_busy), 16'h1);
    ifc.flush = 1'b1;
    #1;
    chk("flush_rdy", 16'(ifc.instr_ready), 16'h0);
    tick();
    ifc.flush       = 1'b0;
    ifc.instr_valid = 1'b0;
    chk("flush_op", 16'(ifc.opcode), 16'h0);
    chk("flush_md", 16'(ifc.multiDiv), 16'h0);
    chk("flush_busy", 16'(ifc.md_busy), 16'h0);
    chk("flush_iv", 16'(ifc.issue_valid), 16'h0);
    chk("flush_count", ifc.issued_count, 16'd8);
    tick();
    chk("flush_count_hold", ifc.issued_count, 16'd8);

    // counter wrap
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = 16'h1123;
    for (int i = 0; i < 65527; i++) @(posedge clk);
    #1;
    chk("wrap_ffff", ifc.issued_count, 16'hFFFF);
    tick();
    chk("wrap_zero", ifc.issued_count, 16'h0000);
    ifc.instr_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
